// File: rtl/reg_access_sequencer_if.sv
// Decode/commit-side request channels and the register-file task port,
// bundled so the sequencer (master) and its environment (slave) share one definition.
interface reg_access_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [4:0]        rs1_id;
    logic [4:0]        rs2_id;
    logic              rd_resp_valid;
    logic              rd_resp_ready;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_id;
    logic [DATA_W-1:0] wb_data;
    logic              rf_have_task;
    logic [4:0]        rf_reg_id;
    logic              rf_rw;
    logic [DATA_W-1:0] rf_data_in;
    logic [DATA_W-1:0] rf_data_out;

    modport master (
        input  rd_req_valid, rs1_id, rs2_id, rd_resp_ready,
               wb_valid, wb_id, wb_data, rf_data_out,
        output rd_req_ready, rd_resp_valid, rs1_val, rs2_val,
               wb_ready, rf_have_task, rf_reg_id, rf_rw, rf_data_in
    );

    modport slave (
        output rd_req_valid, rs1_id, rs2_id, rd_resp_ready,
               wb_valid, wb_id, wb_data, rf_data_out,
        input  rd_req_ready, rd_resp_valid, rs1_val, rs2_val,
               wb_ready, rf_have_task, rf_reg_id, rf_rw, rf_data_in
    );
endinterface

// File: rtl/reg_access_sequencer.sv
// Serialises buffered commit write-backs and operand-pair reads onto the
// single-port register-file task interface; writes always win over reads.
module reg_access_sequencer #(
    parameter int WB_DEPTH = 4,
    parameter int DATA_W   = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_pipline,
    reg_access_sequencer_if.master bus
);
    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, RESP} state_t;

    state_t             state, state_next;
    logic [4:0]         fifo_id   [WB_DEPTH];
    logic [DATA_W-1:0]  fifo_data [WB_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [4:0]         rs1_q, rs2_q;
    logic               active, push, pop, accept, cap1, cap2;
    logic               fifo_empty, fifo_full;

    // Reset and pause both mask every handshake and task strobe combinationally.
    assign active     = rdy_in && !rst_in;
    assign fifo_full  = (count == CNT_W'(WB_DEPTH));
    assign fifo_empty = (count == '0);

    assign bus.wb_ready      = active && !fifo_full;
    assign push              = bus.wb_valid && bus.wb_ready && (bus.wb_id != 5'd0);
    assign bus.rd_resp_valid = (state == RESP);

    always_comb begin
        state_next       = state;
        pop              = 1'b0;
        accept           = 1'b0;
        cap1             = 1'b0;
        cap2             = 1'b0;
        bus.rd_req_ready = 1'b0;
        bus.rf_have_task = 1'b0;
        bus.rf_rw        = 1'b0;
        bus.rf_reg_id    = 5'd0;
        bus.rf_data_in   = '0;
        if (active) begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        bus.rf_have_task = 1'b1;
                        bus.rf_rw        = 1'b1;
                        bus.rf_reg_id    = fifo_id[rd_ptr];
                        bus.rf_data_in   = fifo_data[rd_ptr];
                        pop              = 1'b1;
                    end else if (!flush_pipline) begin
                        bus.rd_req_ready = 1'b1;
                        if (bus.rd_req_valid) begin
                            accept     = 1'b1;
                            state_next = RD1;
                        end
                    end
                end
                RD1: begin
                    if (flush_pipline) begin
                        state_next = IDLE;
                    end else begin
                        bus.rf_have_task = 1'b1;
                        bus.rf_reg_id    = rs1_q;
                        state_next       = RD2;
                    end
                end
                RD2: begin
                    if (flush_pipline) begin
                        state_next = IDLE;
                    end else begin
                        bus.rf_have_task = 1'b1;
                        bus.rf_reg_id    = rs2_q;
                        cap1             = 1'b1;
                        state_next       = CAP;
                    end
                end
                CAP: begin
                    if (flush_pipline) begin
                        state_next = IDLE;
                    end else begin
                        cap2       = 1'b1;
                        state_next = RESP;
                    end
                end
                RESP: begin
                    if (flush_pipline || bus.rd_resp_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.rs1_val <= '0;
            bus.rs2_val <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Register x0 reads as zero whatever the file returns.
            if (cap1) bus.rs1_val <= (rs1_q == 5'd0) ? '0 : bus.rf_data_out;
            if (cap2) bus.rs2_val <= (rs2_q == 5'd0) ? '0 : bus.rf_data_out;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_id[wr_ptr]   <= bus.wb_id;
            fifo_data[wr_ptr] <= bus.wb_data;
        end
        if (accept) begin
            rs1_q <= bus.rs1_id;
            rs2_q <= bus.rs2_id;
        end
    end
endmodule

// File: tb/tb_reg_access_sequencer.sv
// Bench for reg_access_sequencer: behavioural register file, write/read
// scoreboards, a transaction table and directed multi-cycle corner cases.
module tb_reg_access_sequencer;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, flush_pipline;

    reg_access_sequencer_if #(.DATA_W(32)) bus ();

    reg_access_sequencer #(.WB_DEPTH(4), .DATA_W(32)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .bus           (bus.master)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Register file model; x0 deliberately holds garbage, idle cycles return noise.
    logic [31:0] rf_regs [32];
    bit          rf_init = 1'b0;
    always @(posedge clk_in) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++) rf_regs[i] <= (i == 0) ? 32'h0BAD0BAD : {4{8'(i)}};
            rf_init <= 1'b1;
        end else if (bus.rf_have_task && bus.rf_rw) begin
            rf_regs[bus.rf_reg_id] <= bus.rf_data_in;
        end
        if (bus.rf_have_task && !bus.rf_rw) bus.rf_data_out <= rf_regs[bus.rf_reg_id];
        else                                bus.rf_data_out <= $urandom;
    end

    typedef struct packed {logic [4:0] id; logic [31:0] data;} wr_t;
    typedef struct packed {logic [31:0] v1; logic [31:0] v2;} rd_t;
    wr_t         wq [$];
    rd_t         rq [$];
    logic [31:0] arch [32];
    bit          pending = 1'b0;

    // Monitor: expected write tasks and read responses pushed on handshake, popped on output.
    initial begin
        wr_t e;
        rd_t r;
        for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? 32'h0 : {4{8'(i)}};
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                wq.delete();
                rq.delete();
                pending = 1'b0;
            end else begin
                if (bus.rf_have_task && bus.rf_rw) begin
                    if (wq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL wr_task_unexpected: got write to x%0d, expected no write task", bus.rf_reg_id);
                    end else begin
                        e = wq.pop_front();
                        check("wr_task_id", 32'(bus.rf_reg_id), 32'(e.id));
                        check("wr_task_data", bus.rf_data_in, e.data);
                        arch[e.id] = e.data;
                    end
                end
                if (flush_pipline && rdy_in && pending) begin
                    pending = 1'b0;
                    if (rq.size() != 0) rq.delete(0);
                end else if (bus.rd_resp_valid && bus.rd_resp_ready && rdy_in) begin
                    if (rq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rd_resp_unexpected: got response %08h/%08h, expected none", bus.rs1_val, bus.rs2_val);
                    end else begin
                        r = rq.pop_front();
                        check("sb_rs1_val", bus.rs1_val, r.v1);
                        check("sb_rs2_val", bus.rs2_val, r.v2);
                    end
                    pending = 1'b0;
                end
                if (bus.rd_req_valid && bus.rd_req_ready) begin
                    rq.push_back('{v1: arch[bus.rs1_id], v2: arch[bus.rs2_id]});
                    pending = 1'b1;
                end
                if (bus.wb_valid && bus.wb_ready && bus.wb_id != 5'd0)
                    wq.push_back('{id: bus.wb_id, data: bus.wb_data});
            end
        end
    end

    task automatic push_write(input logic [4:0] id, input logic [31:0] data);
        bit ok = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_id    = id;
        bus.wb_data  = data;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in);
            ok = bus.wb_ready;
        end
        @(posedge clk_in); #1;
        bus.wb_valid = 1'b0;
        check("wb_accept", 32'(ok), 32'd1);
    endtask

    task automatic accept_read(input logic [4:0] a, input logic [4:0] b);
        bit ok = 1'b0;
        bus.rd_req_valid = 1'b1;
        bus.rs1_id       = a;
        bus.rs2_id       = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in);
            ok = bus.rd_req_ready;
        end
        @(posedge clk_in); #1;
        bus.rd_req_valid = 1'b0;
        check("rd_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_resp(output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk_in);
            if (bus.rd_resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("rd_resp_arrives", 32'(got), 32'd1);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] e1, input logic [31:0] e2);
        int lat;
        bus.rd_resp_ready = 1'b1;
        accept_read(a, b);
        wait_resp(lat);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_rs1_val", bus.rs1_val, e1);
        check("rd_rs2_val", bus.rs2_val, e2);
        @(posedge clk_in); #1;
    endtask

    typedef struct {
        bit          is_wr;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] d;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;
    vec_t vt [13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int pushes;
        int nxt;
        bit acc;
        bit seen;

        vt[0]  = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        vt[1]  = '{1'b0, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0};
        vt[2]  = '{1'b1, 5'd0,  5'd0,  32'h00000001, 32'h0,        32'h0};
        vt[3]  = '{1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vt[4]  = '{1'b1, 5'd7,  5'd0,  32'h12345678, 32'h0,        32'h0};
        vt[5]  = '{1'b1, 5'd9,  5'd0,  32'hCAFEF00D, 32'h0,        32'h0};
        vt[6]  = '{1'b0, 5'd7,  5'd9,  32'h0,        32'h12345678, 32'hCAFEF00D};
        vt[7]  = '{1'b0, 5'd9,  5'd5,  32'h0,        32'hCAFEF00D, 32'hDEADBEEF};
        vt[8]  = '{1'b1, 5'd5,  5'd0,  32'h00000055, 32'h0,        32'h0};
        vt[9]  = '{1'b0, 5'd5,  5'd7,  32'h0,        32'h00000055, 32'h12345678};
        vt[10] = '{1'b0, 5'd3,  5'd31, 32'h0,        32'h03030303, 32'h1F1F1F1F};
        vt[11] = '{1'b1, 5'd31, 5'd0,  32'hA5A5A5A5, 32'h0,        32'h0};
        vt[12] = '{1'b0, 5'd31, 5'd31, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5};

        rst_in            = 1'b1;
        rdy_in            = 1'b1;
        flush_pipline     = 1'b0;
        bus.rd_req_valid  = 1'b0;
        bus.rs1_id        = 5'd0;
        bus.rs2_id        = 5'd0;
        bus.rd_resp_ready = 1'b1;
        bus.wb_valid      = 1'b0;
        bus.wb_id         = 5'd0;
        bus.wb_data       = 32'h0;

        repeat (2) @(negedge clk_in);
        check("rst_rf_have_task", 32'(bus.rf_have_task), 32'd0);
        check("rst_rf_rw", 32'(bus.rf_rw), 32'd0);
        check("rst_rf_reg_id", 32'(bus.rf_reg_id), 32'd0);
        check("rst_rf_data_in", bus.rf_data_in, 32'h0);
        check("rst_rd_resp_valid", 32'(bus.rd_resp_valid), 32'd0);
        check("rst_rs1_val", bus.rs1_val, 32'h0);
        check("rst_rs2_val", bus.rs2_val, 32'h0);
        check("rst_rd_req_ready", 32'(bus.rd_req_ready), 32'd0);
        check("rst_wb_ready", 32'(bus.wb_ready), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_rst_wb_ready", 32'(bus.wb_ready), 32'd1);
        check("post_rst_rd_req_ready", 32'(bus.rd_req_ready), 32'd1);
        @(posedge clk_in); #1;

        for (int v = 0; v < 13; v++) begin
            if (vt[v].is_wr) begin
                push_write(vt[v].a, vt[v].d);
                if (vt[v].a == 5'd0) begin
                    @(negedge clk_in);
                    check("x0_no_task", 32'(bus.rf_have_task), 32'd0);
                    @(posedge clk_in); #1;
                end
            end else begin
                do_read(vt[v].a, vt[v].b, vt[v].e1, vt[v].e2);
            end
        end

        // Fill the FIFO behind a stalled read response, then drain it.
        bus.rd_resp_ready = 1'b0;
        accept_read(5'd10, 5'd11);
        nxt          = 10;
        bus.wb_valid = 1'b1;
        bus.wb_id    = 5'(nxt);
        bus.wb_data  = 32'h10000000 + 32'(nxt);
        pushes       = 0;
        for (int i = 0; i < 20 && pushes < 4; i++) begin
            @(negedge clk_in);
            acc = bus.wb_ready;
            @(posedge clk_in); #1;
            if (acc) begin
                pushes++;
                nxt++;
                bus.wb_id   = 5'(nxt);
                bus.wb_data = 32'h10000000 + 32'(nxt);
            end
        end
        check("fifo_fill_pushes", 32'(pushes), 32'd4);
        @(negedge clk_in);
        check("wb_ready_full", 32'(bus.wb_ready), 32'd0);
        check("no_write_in_resp", 32'(bus.rf_have_task), 32'd0);
        check("resp_valid_held", 32'(bus.rd_resp_valid), 32'd1);
        check("pre_write_rs1", bus.rs1_val, 32'h0A0A0A0A);
        check("pre_write_rs2", bus.rs2_val, 32'h0B0B0B0B);
        @(posedge clk_in); #1;
        bus.rd_resp_ready = 1'b1;
        @(negedge clk_in);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("first_pop_task", 32'(bus.rf_have_task), 32'd1);
        check("first_pop_rw", 32'(bus.rf_rw), 32'd1);
        check("first_pop_id", 32'(bus.rf_reg_id), 32'd10);
        check("no_same_cycle_credit", 32'(bus.wb_ready), 32'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("fifth_push_ready", 32'(bus.wb_ready), 32'd1);
        check("second_pop_id", 32'(bus.rf_reg_id), 32'd11);
        @(posedge clk_in); #1;
        bus.wb_valid = 1'b0;
        for (int k = 12; k <= 14; k++) begin
            @(negedge clk_in);
            check("drain_task", 32'(bus.rf_have_task), 32'd1);
            check("drain_order_id", 32'(bus.rf_reg_id), 32'(k));
            @(posedge clk_in); #1;
        end
        @(negedge clk_in);
        check("fifo_drained_idle", 32'(bus.rf_have_task), 32'd0);
        @(posedge clk_in); #1;
        do_read(5'd10, 5'd14, 32'h1000000A, 32'h1000000E);

        // Three-cycle pause before the rs1 read is issued.
        accept_read(5'd7, 5'd9);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("pause_no_task", 32'(bus.rf_have_task), 32'd0);
            check("pause_wb_ready", 32'(bus.wb_ready), 32'd0);
            @(posedge clk_in); #1;
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("resume_rs1_task", 32'(bus.rf_have_task), 32'd1);
        check("resume_rs1_id", 32'(bus.rf_reg_id), 32'd7);
        wait_resp(lat);
        check("pause_latency", 32'(3 + 1 + lat), 32'd7);
        check("pause_rs1_val", bus.rs1_val, 32'h12345678);
        check("pause_rs2_val", bus.rs2_val, 32'hCAFEF00D);
        @(posedge clk_in); #1;

        // Flush while the rs2 read would be issued.
        accept_read(5'd3, 5'd4);
        @(negedge clk_in);
        check("flush_rs1_task_id", 32'(bus.rf_reg_id), 32'd3);
        @(posedge clk_in); #1;
        flush_pipline = 1'b1;
        @(negedge clk_in);
        check("flush_no_rs2_task", 32'(bus.rf_have_task), 32'd0);
        @(posedge clk_in); #1;
        flush_pipline = 1'b0;
        @(negedge clk_in);
        check("flush_back_idle", 32'(bus.rd_req_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            seen |= bus.rd_resp_valid;
        end
        check("flush_no_resp", 32'(seen), 32'd0);
        @(posedge clk_in); #1;
        do_read(5'd3, 5'd4, 32'h03030303, 32'h04040404);

        // Flush in IDLE blocks the read accept.
        bus.rd_req_valid = 1'b1;
        bus.rs1_id       = 5'd1;
        bus.rs2_id       = 5'd2;
        flush_pipline    = 1'b1;
        @(negedge clk_in);
        check("flush_idle_blocks", 32'(bus.rd_req_ready), 32'd0);
        @(posedge clk_in); #1;
        flush_pipline    = 1'b0;
        bus.rd_req_valid = 1'b0;
        @(negedge clk_in);
        check("flush_idle_no_read", 32'(bus.rf_have_task), 32'd0);
        @(posedge clk_in); #1;

        // Asynchronous reset in CAP with a write still queued.
        accept_read(5'd5, 5'd7);
        bus.wb_valid = 1'b1;
        bus.wb_id    = 5'd20;
        bus.wb_data  = 32'h77777777;
        @(posedge clk_in); #1;
        bus.wb_valid = 1'b0;
        @(posedge clk_in); #1;
        check("cap_rs1_before_rst", bus.rs1_val, 32'h00000055);
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst_rs1_val", bus.rs1_val, 32'h0);
        check("async_rst_rs2_val", bus.rs2_val, 32'h0);
        check("async_rst_have_task", 32'(bus.rf_have_task), 32'd0);
        check("async_rst_resp_valid", 32'(bus.rd_resp_valid), 32'd0);
        check("async_rst_req_ready", 32'(bus.rd_req_ready), 32'd0);
        check("async_rst_wb_ready", 32'(bus.wb_ready), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_write_lost", 32'(bus.rf_have_task), 32'd0);
        check("rst_idle_ready", 32'(bus.rd_req_ready), 32'd1);
        @(posedge clk_in); #1;
        do_read(5'd20, 5'd5, 32'h14141414, 32'h00000055);

        repeat (3) @(negedge clk_in);
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_access_sequencer.md
# reg_access_sequencer

Initiator side of the register-file task protocol. It serialises commit write-backs and decode operand-pair reads onto the single-port `have_task / reg_id / rw / data_in / data_out` interface of the register file. It buffers write-backs in a small FIFO and sequences two reads per operand request. It sits between decode/commit and the register file, and honours the pipeline flush and the ready/pause conventions.

## Interface
- `WB_DEPTH`, 4, write-back FIFO entries (power of two, ≥2)
- `clk_in` input 1 system clock
- `rst_in` input 1 reset, asynchronous, active-high
- `rdy_in` input 1 ready; low pauses the block
- `flush_pipline` input 1 pipeline flush, one-cycle pulse
- `rd_req_valid` input 1 decode requests operand pair
- `rd_req_ready` output 1 request accepted when valid&ready
- `rs1_id`, `rs2_id` input 5 each, source register ids
- `rd_resp_valid` output 1 operand pair available
- `rd_resp_ready` input 1 consumer takes the pair
- `rs1_val`, `rs2_val` output 32 each, operand values
- `wb_valid` input 1 commit write-back request
- `wb_ready` output 1 FIFO can accept
- `wb_id` input 5 destination register
- `wb_data` input 32 write value
- `rf_have_task` output 1 register-file task strobe
- `rf_reg_id` output 5 task register id
- `rf_rw` output 1 1 = write, 0 = read
- `rf_data_in` output 32 write data
- `rf_data_out` input 32 read data, valid the cycle after a read task

## Operation
- Register-file protocol: a task is one cycle with `rf_have_task`=1. Writes take effect at that edge. A read returns `rf_data_out` in the next cycle.
- Write FIFO: push on `wb_valid&wb_ready`. `wb_ready` = !full, computed from registered count with no same-cycle pop credit. `wb_id`=0 is accepted but not stored.
- FSM states: IDLE, RD1, RD2, CAP, RESP.
- IDLE with FIFO non-empty: issue head as a write (`rf_rw`=1, id/data from head) and pop. Writes always take priority.
- IDLE with FIFO empty: `rd_req_ready`=1. On accept, latch `rs1_id`/`rs2_id` and go to RD1.
- RD1: read task for rs1 → RD2.
- RD2: read task for rs2, capture `rs1_val` from `rf_data_out` → CAP.
- CAP: capture `rs2_val` → RESP. No task is issued in this state.
- A latched id of 0 forces the corresponding value to 0, regardless of `rf_data_out`.
- RESP: `rd_resp_valid`=1 and values held stable until `rd_resp_ready` → IDLE.
- Writes arriving during RD1..RESP are queued only. They are issued after return to IDLE.
- Flush in RD1/RD2/CAP/RESP:
  - Abort to IDLE; latched request discarded.
  - The read task for that cycle is suppressed.
  - `rd_resp_valid` drops next cycle.
- Flush in IDLE: the read accept is blocked (`rd_req_ready`=0); a write issue proceeds.
- The FIFO is never flushed, since commits are architectural.
- `rdy_in`=0 freezes all state, FIFO and outputs, and forces `rf_have_task`=0, `rd_req_ready`=0 and `wb_ready`=0. Flush is ignored while `rdy_in`=0.
- When no task is issued: `rf_have_task`=0, `rf_rw`=0, id/data 0.

## Timing
- Reset (async, asynchronous assert):
  - FSM=IDLE, FIFO empty.
  - Outputs `rf_*`, `rd_resp_valid`, `rs*_val`, `rd_req_ready` and `wb_ready` are all 0.
  - After reset release, `wb_ready`=1 and `rd_req_ready`=1 with `rdy_in`=1.
- Write latency: pushed at edge T, issued as a task during cycle T+1 if IDLE and head. FIFO order is preserved.
- Read latency: accepted at edge T → RD1 in T+1, RD2 in T+2, CAP in T+3, `rd_resp_valid` in T+4.
- Pointers wrap modulo `WB_DEPTH`. Count ranges 0..`WB_DEPTH`.
- Simultaneous push and pop with the FIFO non-full: count unchanged.
- Reset mid-sequence: immediate return to the reset state. Queued writes are lost.

## Test plan
- Write x5=0xDEADBEEF, then an operand read (5,0):
  - One write task, id 5, rw=1.
  - Then reads: rs1_val=0xDEADBEEF, rs2_val=0.
  - `rd_resp_valid` 4 cycles after accept.
- Push 5 writes back-to-back with `WB_DEPTH`=4:
  - `wb_ready` low after the 4th push.
  - 5th push accepted after the first pop.
  - Tasks appear in push order, one per cycle.
- Read pending while writes arrive during RD1/RD2:
  - Read completes with pre-write values.
  - Queued writes are issued after RESP handshake.
- Flush in RD2:
  - No rs2 read task.
  - `rd_resp_valid` never asserts.
  - FSM back in IDLE.
  - Next request returns correct values.
- `rdy_in` low for 3 cycles mid-read:
  - `rf_have_task`=0 throughout the pause.
  - Sequence resumes where it stopped.
  - Latency extended by exactly 3 cycles.
- Write to x0 with value 0x1 pushed:
  - No register-file task issued.
  - Read (0,0) returns 0,0.
- Async reset asserted in CAP:
  - Outputs zero immediately, without waiting for an edge.
